// File: rtl/red_pitaya_pwm_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_pwm_pkg
// Shared definitions for the multi-channel slow-DAC PWM generator.
//   - default parameter constants (channel count, duty width, dither length,
//     PWM period)
//   - default-width configuration word layout {coarse, mask}
//   - width helpers used to size the period/sub-period counters and the
//     duty datapath
// Modules that need the configuration word at non-default widths declare a
// local struct with the same field order, because a package cannot carry a
// parametrised type.
// ---------------------------------------------------------------------------
package red_pitaya_pwm_pkg;

   localparam int PWM_CHN_DEF  = 4;
   localparam int PWM_CW_DEF   = 8;
   localparam int PWM_CYC_DEF  = 16;
   localparam int PWM_FULL_DEF = 156;

   // One channel's configuration word: coarse duty in the upper bits, the
   // per-sub-period dither mask in the lower bits.
   typedef struct packed {
      logic [PWM_CW_DEF-1:0]  coarse;
      logic [PWM_CYC_DEF-1:0] mask;
   } pwm_cfg_def_t;

   // Width of a counter running 0..n-1. Never less than one bit, so a
   // degenerate count of 1 still yields a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/red_pitaya_pwm_ch.sv
// ---------------------------------------------------------------------------
// red_pitaya_pwm_ch
// One PWM channel of the slow-DAC generator.
//   - shadow register takes every write; the active register is reloaded
//     only at the frame boundary, so a frame never mixes old and new values
//   - a write landing in the boundary cycle itself bypasses the shadow and
//     goes straight into the active register
//   - the shared period counter is rotated by a fixed PHASE offset before
//     comparison (PHASE = 0 gives edge-aligned channels)
//   - the dither bit for the current sub-period is added to the coarse duty
//     and compared against the rotated counter; the result is registered
// Ports:
//   pwm_clk   clock
//   pwm_rst   synchronous active-high reset
//   cnt       shared period counter, 0..FULL-1
//   sub       shared sub-period index, 0..CYC-1
//   boundary  high in the last cycle of a frame
//   cfg_dat   this channel's {coarse, mask} word
//   cfg_we    write strobe for cfg_dat
//   pwm       registered PWM output
// ---------------------------------------------------------------------------
module red_pitaya_pwm_ch
   import red_pitaya_pwm_pkg::*;
#(
   parameter int CW    = PWM_CW_DEF,
   parameter int CYC   = PWM_CYC_DEF,
   parameter int FULL  = PWM_FULL_DEF,
   parameter int PHASE = 0,
   localparam int CNTW = cnt_width(FULL),
   localparam int SUBW = cnt_width(CYC)
)(
   input  logic                pwm_clk,
   input  logic                pwm_rst,
   input  logic [CNTW-1:0]     cnt,
   input  logic [SUBW-1:0]     sub,
   input  logic                boundary,
   input  logic [CW+CYC-1:0]   cfg_dat,
   input  logic                cfg_we,
   output logic                pwm
);

   // One spare bit above the wider of duty and counter, so coarse plus the
   // dither bit can never wrap and a coarse above FULL-1 saturates high.
   localparam int VW   = max_int(CW, CNTW) + 1;
   localparam int SUMW = CNTW + 1;
   localparam int OFF  = PHASE % FULL;

   typedef struct packed {
      logic [CW-1:0]  coarse;
      logic [CYC-1:0] mask;
   } cfg_t;

   cfg_t            cfg_word;
   cfg_t            shadow;
   cfg_t            active;
   logic [SUMW-1:0] cnt_sum;
   logic [CNTW-1:0] cnt_k;
   logic            dither;
   logic [VW-1:0]   duty;

   assign cfg_word = cfg_dat;

   // Shadow captures every write; the last write of a frame is what the
   // next boundary will pick up.
   always_ff @(posedge pwm_clk) begin
      if (pwm_rst) begin
         shadow <= '0;
      end else if (cfg_we) begin
         shadow <= cfg_word;
      end
   end

   // Active register only changes at the frame boundary. A write arriving
   // in that very cycle has not reached the shadow yet, so it is forwarded
   // directly to make it count for the frame that is just starting.
   always_ff @(posedge pwm_clk) begin
      if (pwm_rst) begin
         active <= '0;
      end else if (boundary) begin
         active <= cfg_we ? cfg_word : shadow;
      end
   end

   // Rotate the shared counter by this channel's phase offset. The sum is
   // below 2*FULL, so a single conditional subtract is a full modulo.
   always_comb begin
      cnt_sum = {1'b0, cnt} + SUMW'(OFF);
      cnt_k   = cnt_sum[CNTW-1:0];
      if (cnt_sum >= SUMW'(FULL)) begin
         cnt_k = CNTW'(cnt_sum - SUMW'(FULL));
      end
   end

   assign dither = active.mask[sub];
   assign duty   = VW'(active.coarse) + VW'(dither);

   always_ff @(posedge pwm_clk) begin
      if (pwm_rst) begin
         pwm <= 1'b0;
      end else begin
         pwm <= (VW'(cnt_k) < duty);
      end
   end

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// ---------------------------------------------------------------------------
// red_pitaya_pwm_dac
// Multi-channel slow-DAC PWM generator with per-period dither and
// frame-atomic double-buffered configuration.
//   A period is FULL clocks (cnt 0..FULL-1); a frame is CYC periods
//   (sub 0..CYC-1). Channel k's high time in sub-period s is
//   coarse_k + mask_k[s] clocks, clipped at FULL.
// Ports:
//   pwm_clk_i  clock (pwm_clk domain, single clock)
//   pwm_rst_i  synchronous active-high reset
//   cfg_dat_i  CHN words of {coarse[CW-1:0], mask[CYC-1:0]}, channel k at
//              slice k
//   cfg_we_i   per-channel write strobe
//   pwm_o      registered PWM outputs
//   frame_o    one-cycle pulse in the first cycle of each new frame
// Configuration macro:
//   RED_PITAYA_PWM_PHASE_EN  when defined, channel k compares against
//                            (cnt + k*(FULL/CHN)) mod FULL so rising edges
//                            are staggered; sub and the frame boundary stay
//                            on the un-offset counter
// ---------------------------------------------------------------------------
module red_pitaya_pwm_dac
   import red_pitaya_pwm_pkg::*;
#(
   parameter int CHN  = PWM_CHN_DEF,
   parameter int CW   = PWM_CW_DEF,
   parameter int CYC  = PWM_CYC_DEF,
   parameter int FULL = PWM_FULL_DEF
)(
   input  logic                      pwm_clk_i,
   input  logic                      pwm_rst_i,
   input  logic [CHN*(CW+CYC)-1:0]   cfg_dat_i,
   input  logic [CHN-1:0]            cfg_we_i,
   output logic [CHN-1:0]            pwm_o,
   output logic                      frame_o
);

   localparam int CNTW = cnt_width(FULL);
   localparam int SUBW = cnt_width(CYC);
   localparam int WW   = CW + CYC;

   logic [CNTW-1:0] cnt;
   logic [SUBW-1:0] sub;
   logic            cnt_wrap;
   logic            boundary;

   assign cnt_wrap = (cnt == CNTW'(FULL - 1));
   assign boundary = cnt_wrap && (sub == SUBW'(CYC - 1));

   // Shared period counter and sub-period index. frame_o is the registered
   // boundary, so it lands on the cycle with cnt==0, sub==0 that follows a
   // boundary; the first frame after reset has no preceding boundary and
   // therefore no pulse.
   always_ff @(posedge pwm_clk_i) begin
      if (pwm_rst_i) begin
         cnt     <= '0;
         sub     <= '0;
         frame_o <= 1'b0;
      end else begin
         frame_o <= boundary;
         if (cnt_wrap) begin
            cnt <= '0;
            sub <= (sub == SUBW'(CYC - 1)) ? '0 : sub + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < CHN; k++) begin : g_ch
`ifdef RED_PITAYA_PWM_PHASE_EN
      localparam int PHASE = k * (FULL / CHN);
`else
      localparam int PHASE = 0;
`endif

      red_pitaya_pwm_ch #(
         .CW    (CW),
         .CYC   (CYC),
         .FULL  (FULL),
         .PHASE (PHASE)
      ) u_ch (
         .pwm_clk  (pwm_clk_i),
         .pwm_rst  (pwm_rst_i),
         .cnt      (cnt),
         .sub      (sub),
         .boundary (boundary),
         .cfg_dat  (cfg_dat_i[k*WW +: WW]),
         .cfg_we   (cfg_we_i[k]),
         .pwm      (pwm_o[k])
      );
   end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_pwm_dac
// Self-checking bench for red_pitaya_pwm_dac at default parameters.
// A behavioural model derives cnt/sub from the cycle number since reset and
// keeps per-channel shadow/active words; every cycle the DUT outputs are
// compared against it. Directed frames pin the model with hand-computed
// high-time totals, then randomized writes and resets follow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_red_pitaya_pwm_dac;
   import red_pitaya_pwm_pkg::*;

   localparam int CHN   = 4;
   localparam int CW    = 8;
   localparam int CYC   = 16;
   localparam int FULL  = 156;
   localparam int FRAME = FULL * CYC;
   localparam int WW    = CW + CYC;
   localparam int BOUND = 3 * FRAME;

   logic                 pwm_clk_i = 1'b0;
   logic                 pwm_rst_i = 1'b1;
   logic [CHN*WW-1:0]    cfg_dat_i = '0;
   logic [CHN-1:0]       cfg_we_i  = '0;
   logic [CHN-1:0]       pwm_o;
   logic                 frame_o;

   int testCount = 0;
   int failCount = 0;

   red_pitaya_pwm_dac #(
      .CHN  (CHN),
      .CW   (CW),
      .CYC  (CYC),
      .FULL (FULL)
   ) dut (
      .pwm_clk_i (pwm_clk_i),
      .pwm_rst_i (pwm_rst_i),
      .cfg_dat_i (cfg_dat_i),
      .cfg_we_i  (cfg_we_i),
      .pwm_o     (pwm_o),
      .frame_o   (frame_o)
   );

   always #5 pwm_clk_i = ~pwm_clk_i;

   // Behavioural model: t is the index of the current cycle since reset,
   // so cnt = t mod FULL and sub = (t div FULL) mod CYC by definition.
   int              t = 0;
   bit              modelValid = 1'b0;
   logic [CW-1:0]   shC [CHN];
   logic [CW-1:0]   acC [CHN];
   logic [CYC-1:0]  shM [CHN];
   logic [CYC-1:0]  acM [CHN];
   logic [CHN-1:0]  expPwm = '0;
   logic            expFrame = 1'b0;
   int              mCnt, mSub, mLvl;
   bit              mBoundary;

   function automatic int phaseOff(input int k);
`ifdef RED_PITAYA_PWM_PHASE_EN
      return (k * (FULL / CHN)) % FULL;
`else
      return 0 * k;
`endif
   endfunction

   always @(posedge pwm_clk_i) begin
      if (pwm_rst_i) begin
         modelValid = 1'b1;
         t          = 0;
         expPwm     = '0;
         expFrame   = 1'b0;
         for (int k = 0; k < CHN; k++) begin
            shC[k] = '0; shM[k] = '0; acC[k] = '0; acM[k] = '0;
         end
      end else if (modelValid) begin
         mCnt      = t % FULL;
         mSub      = (t / FULL) % CYC;
         mBoundary = ((t % FRAME) == FRAME - 1);
         for (int k = 0; k < CHN; k++) begin
            mLvl      = int'(acC[k]) + int'(acM[k][mSub]);
            expPwm[k] = (((mCnt + phaseOff(k)) % FULL) < mLvl);
         end
         expFrame = mBoundary;
         for (int k = 0; k < CHN; k++) begin
            if (mBoundary) begin
               if (cfg_we_i[k]) {acC[k], acM[k]} = cfg_dat_i[k*WW +: WW];
               else begin acC[k] = shC[k]; acM[k] = shM[k]; end
            end
            if (cfg_we_i[k]) {shC[k], shM[k]} = cfg_dat_i[k*WW +: WW];
         end
         t++;
      end
   end

   int hiTot [CHN];
   int hiPer [CHN];
   int rise  [CHN];
   int gapHigh;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance one cycle and compare the DUT against the model.
   task automatic tick();
      @(negedge pwm_clk_i);
      if (modelValid) begin
         testCount++;
         if (pwm_o !== expPwm || frame_o !== expFrame) begin
            failCount++;
            $display("[TB] FAIL model_cycle t=%0d: pwm_o=%b frame_o=%b, expected pwm_o=%b frame_o=%b",
                     t, pwm_o, frame_o, expPwm, expFrame);
         end
      end
   endtask

   function automatic logic [WW-1:0] packWord(input int coarse, input int mask);
      pwm_cfg_def_t w;
      w.coarse = coarse[CW-1:0];
      w.mask   = mask[CYC-1:0];
      return w;
   endfunction

   task automatic applyStimulus(input logic [CHN-1:0] we, input logic [CHN*WW-1:0] dat);
      cfg_dat_i = dat;
      cfg_we_i  = we;
      tick();
      cfg_we_i  = '0;
   endtask

   task automatic gotoFrame();
      int n;
      n = 0;
      while (frame_o !== 1'b1 && n < BOUND) begin
         tick();
         n++;
      end
      checkOutput("frame_wait", int'(frame_o === 1'b1), 1);
   endtask

   // Count cycles until frame_o after a reset release; also count any high
   // PWM output seen in that first (unannounced) frame.
   task automatic measureGap(input string name);
      int n;
      n = 0;
      gapHigh = 0;
      while (frame_o !== 1'b1 && n < BOUND) begin
         tick();
         n++;
         gapHigh += int'($countones(pwm_o));
      end
      checkOutput(name, n, FRAME);
   endtask

   // Called in a frame_o cycle (position 0). Optionally writes during
   // position 0, then observes positions 1..FRAME, i.e. the outputs
   // produced from the frame that starts here, and ends on the next frame_o.
   task automatic measureFrame(input logic [CHN-1:0] we, input logic [CHN*WW-1:0] dat);
      logic [CHN-1:0] prev;
      int extra;
      extra = 0;
      prev  = pwm_o;
      for (int k = 0; k < CHN; k++) begin
         hiTot[k] = 0; hiPer[k] = 0; rise[k] = 0;
      end
      cfg_dat_i = dat;
      cfg_we_i  = we;
      for (int p = 1; p <= FRAME; p++) begin
         tick();
         if (p == 1) cfg_we_i = '0;
         for (int k = 0; k < CHN; k++) begin
            if (pwm_o[k]) begin
               hiTot[k]++;
               if (p <= FULL) hiPer[k]++;
               if (p <= FULL && !prev[k] && rise[k] == 0) rise[k] = p;
            end
         end
         prev = pwm_o;
         if (p < FRAME && frame_o) extra++;
      end
      checkOutput("frame_no_early_pulse", extra, 0);
      checkOutput("frame_period", int'(frame_o === 1'b1), 1);
   endtask

   task automatic checkTotals(input string tag, input int e0, input int e1, input int e2, input int e3);
      checkOutput({tag, "_ch0"}, hiTot[0], e0);
      checkOutput({tag, "_ch1"}, hiTot[1], e1);
      checkOutput({tag, "_ch2"}, hiTot[2], e2);
      checkOutput({tag, "_ch3"}, hiTot[3], e3);
   endtask

   logic [CHN*WW-1:0] dat;
   int expRise [CHN];

   initial begin
      // Reset and idle behaviour.
      pwm_rst_i = 1'b1;
      repeat (3) tick();
      checkOutput("reset_pwm", int'(pwm_o), 0);
      checkOutput("reset_frame", int'(frame_o), 0);
      pwm_rst_i = 1'b0;
      measureGap("first_frame_gap");
      checkOutput("first_frame_high", gapHigh, 0);
      for (int f = 0; f < 3; f++) begin
         measureFrame('0, '0);
         checkTotals("idle", 0, 0, 0, 0);
      end

      // ch0 {78, 0} and ch1 {10, 0x0001}.
      dat = '0;
      dat[0*WW +: WW] = packWord(78, 16'h0000);
      dat[1*WW +: WW] = packWord(10, 16'h0001);
      measureFrame(4'b0011, dat);
      checkTotals("write_frame_old", 0, 0, 0, 0);
      measureFrame('0, '0);
      checkTotals("duty", 1248, 161, 0, 0);
      checkOutput("ch0_period0", hiPer[0], 78);
      checkOutput("ch0_rise", rise[0], 1);
      checkOutput("ch1_sub0", hiPer[1], 11);

      // Boundary values on all four channels at once.
      dat[0*WW +: WW] = packWord(0,   16'h0000);
      dat[1*WW +: WW] = packWord(155, 16'hFFFF);
      dat[2*WW +: WW] = packWord(200, 16'h0000);
      dat[3*WW +: WW] = packWord(156, 16'h0000);
      measureFrame(4'b1111, dat);
      measureFrame('0, '0);
      checkTotals("edge_vals", 0, FRAME, FRAME, FRAME);

      // Write in the boundary cycle uses the bypass.
      repeat (FRAME - 1) tick();
      dat = '0;
      dat[0*WW +: WW] = packWord(20, 0);
      applyStimulus(4'b0001, dat);
      checkOutput("bypass_frame_start", int'(frame_o), 1);
      measureFrame('0, '0);
      checkOutput("bypass_ch0", hiTot[0], 320);

      // Write one cycle after the boundary waits a whole frame.
      dat[0*WW +: WW] = packWord(40, 0);
      measureFrame(4'b0001, dat);
      checkOutput("late_write_old", hiTot[0], 320);
      measureFrame('0, '0);
      checkOutput("late_write_new", hiTot[0], 640);

      // Two writes in one frame: last wins.
      dat[0*WW +: WW] = packWord(5, 0);
      applyStimulus(4'b0001, dat);
      repeat (100) tick();
      dat[0*WW +: WW] = packWord(100, 0);
      applyStimulus(4'b0001, dat);
      gotoFrame();
      measureFrame('0, '0);
      checkOutput("last_write_wins", hiTot[0], 1600);

      // Reset at cnt=70, sub=5 with a pending shadow write on ch1.
      dat = '0;
      dat[1*WW +: WW] = packWord(50, 0);
      applyStimulus(4'b0010, dat);
      repeat (5 * FULL + 69) tick();
      checkOutput("pre_reset_pwm0", int'(pwm_o[0]), 1);
      pwm_rst_i = 1'b1;
      tick();
      checkOutput("mid_reset_pwm", int'(pwm_o), 0);
      checkOutput("mid_reset_frame", int'(frame_o), 0);
      pwm_rst_i = 1'b0;
      measureGap("post_reset_gap");
      checkOutput("post_reset_high", gapHigh, 0);
      measureFrame('0, '0);
      checkTotals("shadow_cleared", 0, 0, 0, 0);

      // Phase staggering: all channels {39, 0}.
      for (int k = 0; k < CHN; k++) dat[k*WW +: WW] = packWord(39, 0);
      measureFrame(4'b1111, dat);
      measureFrame('0, '0);
      checkTotals("phase_total", 624, 624, 624, 624);
`ifdef RED_PITAYA_PWM_PHASE_EN
      expRise = '{1, 118, 79, 40};
`else
      expRise = '{1, 1, 1, 1};
`endif
      for (int k = 0; k < CHN; k++) checkOutput($sformatf("rise_ch%0d", k), rise[k], expRise[k]);

      // Randomized writes, boundary-aligned writes and occasional resets.
      for (int c = 0; c < 15000; c++) begin
         tick();
         cfg_we_i  = '0;
         pwm_rst_i = 1'b0;
         if ($urandom_range(0, 9) == 0 ||
             ((t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 0)) begin
            cfg_we_i = CHN'($urandom_range(1, (1 << CHN) - 1));
            for (int k = 0; k < CHN; k++)
               cfg_dat_i[k*WW +: WW] = packWord(int'($urandom_range(0, 255)),
                                                int'($urandom_range(0, 65535)));
         end
         if ($urandom_range(0, 2999) == 0) pwm_rst_i = 1'b1;
      end
      cfg_we_i  = '0;
      pwm_rst_i = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
